// File: rtl/osd_dbg_pkg.sv
// Shared types and constants for the OSD field refresh scheduler.
package osd_dbg_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    START   = 3'd2,
    WAIT_HI = 3'd3,
    WAIT_LO = 3'd4
  } state_e;

  localparam logic [7:0] CHAR_SPACE = 8'h20;

  // Pointer width that never collapses to zero bits for a single field.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/osd_rr_pick.sv
// Combinational round-robin picker: first set bit at or after ptr_i, wrapping.
module osd_rr_pick #(
  parameter int N  = 8,
  parameter int PW = osd_dbg_pkg::ptr_w(N)
) (
  input  logic [N-1:0]  dirty_i,
  input  logic [PW-1:0] ptr_i,
  output logic [PW-1:0] idx_o,
  output logic          vld_o
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [PW:0]    off;
  logic [PW:0]    sum;

  assign dbl   = {dirty_i, dirty_i};
  assign vld_o = |dirty_i;

  // Rotate so bit 0 is the pointer slot, take the lowest set bit, un-rotate.
  always_comb begin
    rot = N'(dbl >> ptr_i);
    off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) off = (PW+1)'(k);
    end
    sum = {1'b0, ptr_i} + off;
    if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
    idx_o = sum[PW-1:0];
  end

endmodule

// File: rtl/osd_field_refresh_scheduler.sv
// Keeps OSD text fields in sync with their requested string indices:
// blanks a dirty field, then hands it to the string writer, one field at a time.
module osd_field_refresh_scheduler
  import osd_dbg_pkg::*;
#(
  parameter int NUM_FIELDS = 8,
  parameter int IDX_W      = 6,
  parameter int ADDR_W     = 11,
  parameter int COLS       = 32,
  parameter int ROW0       = 2,
  parameter int COL0       = 4,
  parameter int FIELD_W    = 26
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_FIELDS*IDX_W-1:0] field_idx_i,
  input  logic                        refresh_all_i,
  output logic                        sw_start_o,
  output logic [IDX_W-1:0]            sw_index_o,
  output logic [ADDR_W-1:0]           sw_base_o,
  input  logic                        sw_busy_i,
  input  logic                        sw_wr_en_i,
  input  logic [ADDR_W-1:0]           sw_wr_addr_i,
  input  logic [7:0]                  sw_wr_data_i,
  output logic                        ram_wr_en_o,
  output logic [ADDR_W-1:0]           ram_wr_addr_o,
  output logic [7:0]                  ram_wr_data_o,
  output logic                        busy_o
);

  localparam int PW = ptr_w(NUM_FIELDS);
  localparam int CW = ptr_w(FIELD_W);

  // Fields must fit in the char RAM and each blank span inside its row.
  if (((ROW0 + NUM_FIELDS) * COLS > (1 << ADDR_W)) || (COL0 + FIELD_W > COLS)) begin : g_geom_bad
    $error("osd_field_refresh_scheduler: field geometry does not fit the char RAM");
  end

  function automatic logic [ADDR_W-1:0] base_of(input logic [PW-1:0] f);
    return ADDR_W'((ROW0 + int'(f)) * COLS + COL0);
  endfunction

  state_e                             state_q, state_d;
  logic [NUM_FIELDS-1:0][IDX_W-1:0]   idx_w, shadow_q, shadow_d;
  logic [NUM_FIELDS-1:0]              force_q, force_d, dirty;
  logic [PW-1:0]                      rr_q, rr_d, sel_q, sel_d, pick_idx;
  logic                               pick_vld;
  logic [IDX_W-1:0]                   cap_q, cap_d, swidx_q, swidx_d;
  logic [ADDR_W-1:0]                  caddr_q, caddr_d, swbase_q, swbase_d;
  logic [CW-1:0]                      col_q, col_d;

  assign idx_w = field_idx_i;

  for (genvar f = 0; f < NUM_FIELDS; f++) begin : g_dirty
    assign dirty[f] = force_q[f] | (idx_w[f] != shadow_q[f]);
  end

  osd_rr_pick #(.N(NUM_FIELDS), .PW(PW)) u_pick (
    .dirty_i (dirty),
    .ptr_i   (rr_q),
    .idx_o   (pick_idx),
    .vld_o   (pick_vld)
  );

  assign busy_o     = (state_q != IDLE);
  assign sw_start_o = (state_q == START);
  assign sw_index_o = swidx_q;
  assign sw_base_o  = swbase_q;

  // Blanking owns the RAM port only in CLEAR; otherwise the writer passes straight through.
  assign ram_wr_en_o   = (state_q == CLEAR) ? 1'b1       : sw_wr_en_i;
  assign ram_wr_addr_o = (state_q == CLEAR) ? caddr_q    : sw_wr_addr_i;
  assign ram_wr_data_o = (state_q == CLEAR) ? CHAR_SPACE : sw_wr_data_i;

  // Next-state logic: pick, blank, start, then wait out the writer's busy pulse.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    force_d  = force_q;
    rr_d     = rr_q;
    sel_d    = sel_q;
    cap_d    = cap_q;
    col_d    = col_q;
    caddr_d  = caddr_q;
    swidx_d  = swidx_q;
    swbase_d = swbase_q;
    case (state_q)
      IDLE: if (pick_vld && !sw_busy_i) begin
        sel_d             = pick_idx;
        cap_d             = idx_w[pick_idx];
        force_d[pick_idx] = 1'b0;
        col_d             = '0;
        caddr_d           = base_of(pick_idx);
        state_d           = CLEAR;
      end
      CLEAR: begin
        col_d   = col_q + 1'b1;
        caddr_d = caddr_q + 1'b1;
        if (col_q == CW'(FIELD_W - 1)) begin
          swidx_d  = cap_q;
          swbase_d = base_of(sel_q);
          state_d  = START;
        end
      end
      START:   state_d = WAIT_HI;
      WAIT_HI: if (sw_busy_i) state_d = WAIT_LO;
      WAIT_LO: if (!sw_busy_i) begin
        // Commit the captured index; a change that landed mid-draw keeps the field dirty.
        shadow_d[sel_q] = cap_q;
        rr_d            = (sel_q == PW'(NUM_FIELDS - 1)) ? '0 : sel_q + 1'b1;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A refresh landing on the pick cycle wins, so the picked field is drawn again.
    if (refresh_all_i) force_d = '1;
  end

  // State registers; reset forces every field so the whole screen is redrawn.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      shadow_q <= '1;
      force_q  <= '1;
      rr_q     <= '0;
      sel_q    <= '0;
      cap_q    <= '0;
      col_q    <= '0;
      caddr_q  <= '0;
      swidx_q  <= '0;
      swbase_q <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      force_q  <= force_d;
      rr_q     <= rr_d;
      sel_q    <= sel_d;
      cap_q    <= cap_d;
      col_q    <= col_d;
      caddr_q  <= caddr_d;
      swidx_q  <= swidx_d;
      swbase_q <= swbase_d;
    end
  end

endmodule
